// File: rtl/RSA_pkg.sv
// RSA_pkg: shared RSA types (operand width, key type, arbiter FSM state, latched job)
package RSA_pkg;
    localparam int MOD_WIDTH = 32;
    typedef logic [MOD_WIDTH-1:0] KeyType;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ArbState_t;
    typedef struct packed {
        KeyType base;
        KeyType msg;
        KeyType key;
        KeyType modulus;
    } RsaJob_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit scanning from rr_ptr upward with wrap
//   req    : request vector
//   rr_ptr : highest-priority index this cycle
//   found  : any request set
//   idx    : winning index (0 when nothing is found)
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [W-1:0] c;
    // Scan from the farthest offset down so the nearest-to-pointer request wins last.
    always_comb begin
        found = |req;
        idx = '0;
        c = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = W'((int'(rr_ptr) + i) % N);
            if (req[c]) idx = c;
        end
    end
endmodule

// File: rtl/rsa_mont_arbiter.sv
// rsa_mont_arbiter: round-robin sharing of one RSA modexp engine among N_REQ job sources
//   clk, rst (async, active-low)
//   req_valid/req_ready + req_base/msg/key/modulus : per-requester job input
//   rsp_valid/rsp_ready + rsp_crypto               : per-requester result, data broadcast
//   eng_i_valid/eng_i_ready + eng_base/msg/key/modulus : job to engine
//   eng_o_valid/eng_o_ready + eng_crypto           : result from engine
//   busy : FSM not in IDLE
//   RSA_ARB_STATS_EN adds done_count (per-requester saturating) and busy_cycles (wrapping)
module rsa_mont_arbiter
    import RSA_pkg::*;
#(
    parameter int   N_REQ = 4,
    localparam int  GW    = $clog2(N_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_base,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_msg,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_key,
    input  logic [N_REQ-1:0][MOD_WIDTH-1:0] req_modulus,
    output logic [N_REQ-1:0]                rsp_valid,
    input  logic [N_REQ-1:0]                rsp_ready,
    output logic [MOD_WIDTH-1:0]            rsp_crypto,
    output logic                            eng_i_valid,
    input  logic                            eng_i_ready,
    output logic [MOD_WIDTH-1:0]            eng_base,
    output logic [MOD_WIDTH-1:0]            eng_msg,
    output logic [MOD_WIDTH-1:0]            eng_key,
    output logic [MOD_WIDTH-1:0]            eng_modulus,
    input  logic                            eng_o_valid,
    output logic                            eng_o_ready,
    input  logic [MOD_WIDTH-1:0]            eng_crypto,
    output logic                            busy
`ifdef RSA_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0]          done_count,
    output logic [31:0]                     busy_cycles
`endif
);
    ArbState_t     state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          req_fire;
    logic          rsp_fire;
    RsaJob_t       job;
    KeyType        result;

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        req_fire    = state == IDLE && pick_found;
        rsp_fire    = state == RESP && rsp_ready[grant];
        req_ready   = req_fire ? N_REQ'(1) << pick_idx : '0;
        rsp_valid   = state == RESP ? N_REQ'(1) << grant : '0;
        rsp_crypto  = result;
        eng_i_valid = state == ISSUE;
        eng_o_ready = state == WAIT;
        busy        = state != IDLE;
        eng_base    = job.base;
        eng_msg     = job.msg;
        eng_key     = job.key;
        eng_modulus = job.modulus;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            job    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (req_fire) begin
                    grant <= pick_idx;
                    job   <= '{base: req_base[pick_idx], msg: req_msg[pick_idx],
                               key: req_key[pick_idx], modulus: req_modulus[pick_idx]};
                    state <= ISSUE;
                end
                ISSUE: if (eng_i_ready) state <= WAIT;
                WAIT: if (eng_o_valid) begin
                    result <= eng_crypto;
                    state  <= RESP;
                end
                RESP: if (rsp_fire) begin
                    // Pointer moves past the requester just served so it drops to lowest priority.
                    rr_ptr <= GW'((int'(grant) + 1) % N_REQ);
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef RSA_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_count  <= '0;
            busy_cycles <= '0;
        end else begin
            busy_cycles <= busy_cycles + 32'(busy);
            if (rsp_fire && done_count[grant] != 16'hFFFF) done_count[grant] <= done_count[grant] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// tb_rsa_mont_arbiter: directed bench with an engine stub (accept after acc_delay cycles, msg^key after 5)
module tb_rsa_mont_arbiter;
    localparam logic [31:0] MSG  [4] = '{32'h0000_00F0, 32'h0000_0005, 32'hA5A5_A5A5, 32'h1234_5678};
    localparam logic [31:0] KEY  [4] = '{32'h0000_000F, 32'h0000_0003, 32'hFFFF_0000, 32'h1111_1111};
    localparam logic [31:0] BASE [4] = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    localparam logic [31:0] MODU [4] = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
    localparam logic [31:0] EXPR [4] = '{32'h0000_00FF, 32'h0000_0006, 32'h5A5A_A5A5, 32'h0325_4769};

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][31:0] req_base, req_msg, req_key, req_modulus;
    logic [3:0]       rsp_valid;
    logic [3:0]       rsp_ready;
    logic [31:0]      rsp_crypto;
    logic             eng_i_valid, eng_i_ready;
    logic [31:0]      eng_base, eng_msg, eng_key, eng_modulus;
    logic             eng_o_valid, eng_o_ready;
    logic [31:0]      eng_crypto;
    logic             busy;
`ifdef RSA_ARB_STATS_EN
    logic [3:0][15:0] done_count;
    logic [31:0]      busy_cycles;
    int               bcnt = 0;
`endif
    int errors = 0;
    int checks = 0;
    int acc_delay = 2;
    int accepts = 0;

    rsa_mont_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_msg(req_msg), .req_key(req_key), .req_modulus(req_modulus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_crypto(rsp_crypto),
        .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
        .eng_base(eng_base), .eng_msg(eng_msg), .eng_key(eng_key), .eng_modulus(eng_modulus),
        .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_crypto(eng_crypto),
        .busy(busy)
`ifdef RSA_ARB_STATS_EN
        , .done_count(done_count), .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin : stub
        logic        i_fire, o_fire, iv, pend;
        logic [31:0] val, res;
        int          acc, lat;
        eng_i_ready = 0; eng_o_valid = 0; eng_crypto = 0;
        pend = 0; acc = 0; lat = 0; res = 0;
        forever begin
            @(negedge clk);
            i_fire = eng_i_valid && eng_i_ready;
            o_fire = eng_o_valid && eng_o_ready;
            iv     = eng_i_valid;
            val    = eng_msg ^ eng_key;
            @(posedge clk); #1;
            if (!rst) begin
                eng_i_ready = 0; eng_o_valid = 0; eng_crypto = 0; pend = 0; acc = 0; lat = 0;
            end else begin
                if (o_fire) begin
                    eng_o_valid = 0; pend = 0;
                end else if (pend && !eng_o_valid) begin
                    lat++;
                    if (lat >= 5) begin eng_o_valid = 1; eng_crypto = res; end
                end
                if (i_fire) begin
                    pend = 1; lat = 0; res = val; acc = 0; eng_i_ready = 0; accepts++;
                end else if (iv) begin
                    acc++; eng_i_ready = acc >= acc_delay;
                end else begin
                    acc = 0; eng_i_ready = 0;
                end
            end
        end
    end

`ifdef RSA_ARB_STATS_EN
    initial forever begin
        @(negedge clk);
        if (!rst) bcnt = 0;
        else if (busy) bcnt++;
    end
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input int idx, input string tag);
        int n = 0;
        logic [3:0] e = 4'b0001 << idx;
        @(negedge clk);
        while (req_ready == '0 && n < 60) begin @(negedge clk); n++; end
        chk(tag, req_ready, e);
    endtask

    task automatic wait_rsp(input int idx, input string tag);
        int n = 0;
        logic [3:0] e = 4'b0001 << idx;
        @(negedge clk);
        while (rsp_valid == '0 && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_vld"}, rsp_valid, e);
        chk({tag, "_data"}, rsp_crypto, EXPR[idx]);
    endtask

    initial begin
        int n, a0;
        rst = 0; req_valid = 0; rsp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_base[i] = BASE[i]; req_msg[i] = MSG[i]; req_key[i] = KEY[i]; req_modulus[i] = MODU[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_iv", eng_i_valid, 0);
        chk("rst_or", eng_o_ready, 0);
        chk("rst_ops", {eng_base, eng_msg, eng_key, eng_modulus}, 0);
        step(); rst = 1;

        step(); req_valid = 4'b0010;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0010);
        step(); req_valid = 0;
        @(negedge clk);
        chk("t1_iv", eng_i_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_ops", {eng_msg, eng_key}, {32'h5, 32'h3});
        wait_rsp(1, "t1_rsp");
        step(); req_valid = 4'b1011;
        wait_grant(3, "t1_ptr");
        step(); req_valid = 0;
        wait_rsp(3, "t1_rsp3");

        step(); req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(k % 4, "t2_grant");
            wait_rsp(k % 4, "t2_rsp");
        end
        step(); req_valid = 0;

        step(); rsp_ready = 4'b1011; req_valid = 4'b0100;
        wait_grant(2, "t3_grant");
        step(); req_valid = 4'b1111;
        wait_rsp(2, "t3_rsp");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_vld", rsp_valid, 4'b0100);
            chk("t3_hold_data", rsp_crypto, EXPR[2]);
            chk("t3_hold_iv", eng_i_valid, 0);
            chk("t3_hold_rdy", req_ready, 0);
        end
        step(); rsp_ready = 4'b1111;
        wait_grant(3, "t3_next");
        step(); req_valid = 0;
        wait_rsp(3, "t3_rsp3");

        acc_delay = 7; a0 = accepts;
        step(); req_valid = 4'b0001;
        wait_grant(0, "t4_grant");
        step(); req_valid = 0; req_msg[0] = 32'hDEAD_BEEF; req_key[0] = 32'h0BAD_F00D;
        n = 0;
        do begin
            @(negedge clk);
            if (eng_i_valid) begin
                chk("t4_ops", {eng_base, eng_msg, eng_key, eng_modulus}, {BASE[0], MSG[0], KEY[0], MODU[0]});
                n++;
            end
        end while (eng_i_valid && n < 20);
        chk("t4_issue_len", n, 8);
        wait_rsp(0, "t4_rsp");
        chk("t4_one_issue", accepts - a0, 1);
        acc_delay = 2; req_msg[0] = MSG[0]; req_key[0] = KEY[0];

        step(); req_valid = 4'b0010;
        wait_grant(1, "t5_grant");
        step(); req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!eng_o_ready && n < 50);
        chk("t5_wait", eng_o_ready, 1);
        #1 rst = 0;
        step();
        chk("t5_busy", busy, 0);
        chk("t5_outs", {req_ready, rsp_valid, eng_i_valid, eng_o_ready}, 0);
        chk("t5_ops", {eng_base, eng_msg, eng_key, eng_modulus}, 0);
        chk("t5_rsp_data", rsp_crypto, 0);
        step(); step(); rst = 1;
        step(); req_valid = 4'b1001;
        wait_grant(0, "t5_ptr");
        step(); req_valid = 4'b1000;
        wait_rsp(0, "t5_rsp0");
        wait_grant(3, "t5_grant3");
        step(); req_valid = 0;
        wait_rsp(3, "t5_rsp3");

`ifdef RSA_ARB_STATS_EN
        step(); rst = 0;
        step(); step(); rst = 1;
        step(); req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            wait_grant(0, "t6_grant");
            wait_rsp(0, "t6_rsp");
        end
        step(); req_valid = 0;
        @(negedge clk);
        chk("t6_done", done_count, {16'd0, 16'd0, 16'd0, 16'd3});
        chk("t6_busy_cycles", busy_cycles, bcnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
